// File: rtl/bf_exec_core.sv
// Brainfuck execution core: sequences 3-bit opcodes from an async program ROM, owns the
// data pointer and loop-return stack, and moves bytes over ready/valid out/in streams.
module bf_exec_core #(
    parameter int RAM_AW      = 8,
    parameter int DW          = 8,
    parameter int ROM_AW      = 10,
    parameter int STACK_DEPTH = 8,
    parameter int SKIP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [2:0]        opcode,
    input  logic              prog_end,
    output logic [RAM_AW-1:0] mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_we,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_INC   = 3'b111;
    localparam logic [2:0] OP_DEC   = 3'b110;
    localparam logic [2:0] OP_RIGHT = 3'b101;
    localparam logic [2:0] OP_LEFT  = 3'b100;
    localparam logic [2:0] OP_OPEN  = 3'b011;
    localparam logic [2:0] OP_CLOSE = 3'b010;
    localparam logic [2:0] OP_OUT   = 3'b001;
    localparam logic [2:0] OP_IN    = 3'b000;

    typedef enum logic [2:0] {
        S_RUN, S_SKIP, S_WAIT_OUT, S_WAIT_IN, S_HALT, S_ERR
    } state_t;

    state_t            state_q;
    logic [ROM_AW-1:0] pc_q;
    logic [RAM_AW-1:0] ptr_q;
    logic [SP_W-1:0]   sp_q;
    logic [SKIP_W-1:0] skip_q;
    logic [DW-1:0]     out_data_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              halted_q;
    logic              error_q;
    logic [1:0]        err_code_q;
    logic [ROM_AW-1:0] stack_q [STACK_DEPTH];

    logic [ROM_AW-1:0] pc_inc;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [ROM_AW-1:0] stack_top;
    logic              cell_nz;
    logic              sp_full;
    logic              run_now;
    logic              push_en;

    assign pc_inc    = pc_q + ROM_AW'(1);
    assign push_idx  = IDX_W'(sp_q);
    assign top_idx   = IDX_W'(sp_q - SP_W'(1));
    assign stack_top = stack_q[top_idx];
    assign cell_nz   = |mem_rdata;
    assign sp_full   = (sp_q == SP_W'(STACK_DEPTH));
    assign run_now   = rst_n && enable && (state_q == S_RUN) && !prog_end;
    assign push_en   = run_now && (opcode == OP_OPEN) && cell_nz && !sp_full;

    // RAM write port is combinational so the cell update lands on the same edge as pc+1.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = mem_rdata;
        if (run_now && opcode == OP_INC) begin
            mem_we    = 1'b1;
            mem_wdata = mem_rdata + DW'(1);
        end else if (run_now && opcode == OP_DEC) begin
            mem_we    = 1'b1;
            mem_wdata = mem_rdata - DW'(1);
        end else if (rst_n && enable && state_q == S_WAIT_IN && in_valid && in_ready_q) begin
            mem_we    = 1'b1;
            mem_wdata = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            pc_q        <= '0;
            ptr_q       <= '0;
            sp_q        <= '0;
            skip_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
        end else if (enable) begin
            case (state_q)
                S_RUN: begin
                    if (prog_end) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_INC, OP_DEC: pc_q <= pc_inc;
                            OP_RIGHT: begin
                                ptr_q <= ptr_q + RAM_AW'(1);
                                pc_q  <= pc_inc;
                            end
                            OP_LEFT: begin
                                ptr_q <= ptr_q - RAM_AW'(1);
                                pc_q  <= pc_inc;
                            end
                            OP_OPEN: begin
                                if (!cell_nz) begin
                                    skip_q  <= '0;
                                    pc_q    <= pc_inc;
                                    state_q <= S_SKIP;
                                end else if (sp_full) begin
                                    state_q    <= S_ERR;
                                    error_q    <= 1'b1;
                                    err_code_q <= 2'd1;
                                end else begin
                                    sp_q <= sp_q + SP_W'(1);
                                    pc_q <= pc_inc;
                                end
                            end
                            OP_CLOSE: begin
                                if (sp_q == '0) begin
                                    state_q    <= S_ERR;
                                    error_q    <= 1'b1;
                                    err_code_q <= 2'd2;
                                end else if (cell_nz) begin
                                    // Stack holds the address just past '[', so the loop re-enters its body.
                                    pc_q <= stack_top;
                                end else begin
                                    sp_q <= sp_q - SP_W'(1);
                                    pc_q <= pc_inc;
                                end
                            end
                            OP_OUT: begin
                                out_data_q  <= mem_rdata;
                                out_valid_q <= 1'b1;
                                state_q     <= S_WAIT_OUT;
                            end
                            default: begin
                                in_ready_q <= 1'b1;
                                state_q    <= S_WAIT_IN;
                            end
                        endcase
                    end
                end
                S_SKIP: begin
                    if (prog_end) begin
                        state_q    <= S_ERR;
                        error_q    <= 1'b1;
                        err_code_q <= 2'd3;
                    end else begin
                        pc_q <= pc_inc;
                        if (opcode == OP_OPEN && skip_q != '1) begin
                            skip_q <= skip_q + SKIP_W'(1);
                        end else if (opcode == OP_CLOSE) begin
                            if (skip_q == '0) begin
                                state_q <= S_RUN;
                            end else begin
                                skip_q <= skip_q - SKIP_W'(1);
                            end
                        end
                    end
                end
                S_WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= pc_inc;
                        state_q     <= S_RUN;
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        pc_q       <= pc_inc;
                        state_q    <= S_RUN;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr  = pc_q;
    assign mem_addr  = ptr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign halted    = halted_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_bf_exec_core.sv
// Bench for bf_exec_core: runs small Brainfuck programs against a program-level interpreter
// model and checks streams, final RAM, halt/error status plus hand-computed literals.
module tb_bf_exec_core;

    localparam int RAM_AW = 8;
    localparam int DW     = 8;
    localparam int ROM_AW = 10;
    localparam int SD     = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [ROM_AW-1:0] rom_addr;
    logic [2:0]        opcode;
    logic              prog_end;
    logic [RAM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_rdata;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              halted;
    logic              error;
    logic [1:0]        err_code;

    always #5 clk = ~clk;

    bf_exec_core #(
        .RAM_AW(RAM_AW), .DW(DW), .ROM_AW(ROM_AW), .STACK_DEPTH(SD), .SKIP_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .rom_addr(rom_addr), .opcode(opcode), .prog_end(prog_end),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .halted(halted), .error(error), .err_code(err_code)
    );

    // Program ROM and data RAM owned by the bench
    logic [2:0] rom [1024];
    int         prog_len = 0;
    logic [7:0] ram [256];
    logic       ram_clr = 1'b0;

    assign prog_end  = (int'(rom_addr) >= prog_len);
    assign opcode    = prog_end ? 3'b000 : rom[rom_addr];
    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] enc(input byte c);
        case (c)
            "+": return 3'b111;
            "-": return 3'b110;
            ">": return 3'b101;
            "<": return 3'b100;
            "[": return 3'b011;
            "]": return 3'b010;
            ".": return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic load(input string p);
        for (int i = 0; i < p.len(); i++) rom[i] = enc(p[i]);
        prog_len = p.len();
    endtask

    // Interpreter model: language semantics over the whole program.
    logic [7:0] m_ram [256];
    logic [7:0] m_out [$];
    int         m_err;
    bit         m_halt;

    task automatic model_run(input string p, input int in_b);
        int         pc;
        logic [7:0] ptr;
        int         stk [$];
        logic [7:0] inq [$];
        pc = 0;
        ptr = 8'h00;
        for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
        m_out.delete();
        m_err = 0;
        m_halt = 0;
        if (in_b >= 0) inq.push_back(in_b[7:0]);
        for (int step = 0; step < 20000; step++) begin
            if (pc >= p.len()) begin
                m_halt = 1;
                return;
            end
            case (p[pc])
                "+": begin m_ram[ptr] = m_ram[ptr] + 8'd1; pc++; end
                "-": begin m_ram[ptr] = m_ram[ptr] - 8'd1; pc++; end
                ">": begin ptr = ptr + 8'd1; pc++; end
                "<": begin ptr = ptr - 8'd1; pc++; end
                "[": begin
                    if (m_ram[ptr] != 0) begin
                        if (stk.size() == SD) begin m_err = 1; return; end
                        stk.push_back(pc + 1);
                        pc++;
                    end else begin
                        int d = 0;
                        int q = pc + 1;
                        bit found = 0;
                        while (q < p.len()) begin
                            if (p[q] == "[") d++;
                            else if (p[q] == "]") begin
                                if (d == 0) begin found = 1; break; end
                                d--;
                            end
                            q++;
                        end
                        if (!found) begin m_err = 3; return; end
                        pc = q + 1;
                    end
                end
                "]": begin
                    if (stk.size() == 0) begin m_err = 2; return; end
                    if (m_ram[ptr] != 0) pc = stk[$];
                    else begin void'(stk.pop_back()); pc++; end
                end
                ".": begin m_out.push_back(m_ram[ptr]); pc++; end
                default: begin m_ram[ptr] = inq.pop_front(); pc++; end
            endcase
        end
    endtask

    // Per-cycle compare process
    bit         chk_en = 0;
    int         exp_idx = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_in_acc = 1'b0;
    logic [7:0] dut_out [$];

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (prev_hold) begin
                check("out_hold_valid", 32'(out_valid), 32'd1);
                check("out_hold_data", 32'(out_data), 32'(prev_data));
            end
            if (prev_in_acc) check("in_ready_drop", 32'(in_ready), 32'd0);
            if (enable && out_valid && out_ready) begin
                if (exp_idx < m_out.size()) check("out_byte", 32'(out_data), 32'(m_out[exp_idx]));
                else check("out_extra", 32'(exp_idx), 32'(m_out.size()));
                dut_out.push_back(out_data);
                exp_idx++;
            end
            if (enable && in_valid && in_ready) begin
                check("in_we", 32'(mem_we), 32'd1);
                check("in_wdata", 32'(mem_wdata), 32'(in_data));
            end
            if (halted || error) check("term_quiet", 32'({out_valid, in_ready, mem_we}), 32'd0);
            prev_hold   = out_valid && !(enable && out_ready);
            prev_data   = out_data;
            prev_in_acc = enable && in_valid && in_ready;
        end else begin
            prev_hold   = 1'b0;
            prev_in_acc = 1'b0;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        ram_clr   = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        ram_clr = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic run_prog(input string name, input string p, input int in_b,
                            input int in_dly, input int out_dly, input int budget);
        bit done = 0;
        int ocnt = 0;
        int icnt = 0;
        int bad = 0;
        load(p);
        model_run(p, in_b);
        do_reset();
        dut_out.delete();
        exp_idx = 0;
        chk_en = 1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) ocnt++; else ocnt = 0;
            out_ready = (ocnt > out_dly);
            if (in_ready) icnt++; else icnt = 0;
            in_valid = (icnt > in_dly);
            in_data  = in_valid ? in_b[7:0] : 8'h00;
            if (halted || error) begin done = 1; break; end
        end
        if (!done) check({name, "_timeout"}, 32'(halted || error), 32'd1);
        repeat (2) @(negedge clk);
        chk_en = 0;
        check({name, "_halted"}, 32'(halted), 32'(m_halt));
        check({name, "_error"}, 32'(error), 32'(m_err != 0));
        check({name, "_err_code"}, 32'(err_code), 32'(m_err));
        check({name, "_nout"}, 32'(dut_out.size()), 32'(m_out.size()));
        for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) bad++;
        check({name, "_ram"}, 32'(bad), 32'd0);
        $display("prog %-12s \"%s\": outs=%0d halted=%0d error=%0d err_code=%0d",
                 name, p, dut_out.size(), halted, error, err_code);
    endtask

    task automatic check_out0(input string name, input logic [7:0] exp);
        if (dut_out.size() > 0) check(name, 32'(dut_out[0]), 32'(exp));
        else check({name, "_missing"}, 32'(dut_out.size()), 32'd1);
    endtask

    string deep;
    logic [ROM_AW-1:0] snap_pc;
    logic [RAM_AW-1:0] snap_ptr;
    logic [7:0]        snap_r1;
    bit                seen;

    initial begin
        rst_n = 1'b0; enable = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset state with '+' presented: no write may leak through
        load("+");
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        $display("reset state checked");

        run_prog("out3", "+++.", -1, 0, 5, 100);
        check_out0("out3_byte", 8'h03);
        check("out3_halted_lit", 32'(halted), 32'd1);

        run_prog("wrap_dec", "-.", -1, 0, 0, 100);
        check_out0("wrap_dec_byte", 8'hFF);

        run_prog("ptr_wrap", "<+", -1, 0, 0, 100);
        check("ptr_wrap_ram255", 32'(ram[255]), 32'd1);
        check("ptr_wrap_ram0", 32'(ram[0]), 32'd0);

        run_prog("loop", "++[->+<]>.", -1, 0, 1, 200);
        check_out0("loop_byte", 8'h02);
        check("loop_ram0", 32'(ram[0]), 32'd0);
        check("loop_ram1", 32'(ram[1]), 32'd2);

        run_prog("nested_skip", "[[+]+]+.", -1, 0, 0, 100);
        check_out0("nested_skip_byte", 8'h01);
        check("nested_skip_ram0", 32'(ram[0]), 32'd1);

        run_prog("echo", ",.", 8'h41, 4, 0, 100);
        check_out0("echo_byte", 8'h41);
        check("echo_ram0", 32'(ram[0]), 32'h41);
        check("echo_in_ready_low", 32'(in_ready), 32'd0);

        deep = "";
        for (int i = 0; i <= SD; i++) deep = {deep, "+["};
        run_prog("overflow", deep, -1, 0, 0, 200);
        check("overflow_code_lit", 32'(err_code), 32'd1);

        run_prog("lone_close", "]", -1, 0, 0, 50);
        check("lone_close_code_lit", 32'(err_code), 32'd2);

        run_prog("open_end", "[", -1, 0, 0, 50);
        check("open_end_code_lit", 32'(err_code), 32'd3);

        // enable=0 in the middle of a never-ending loop
        load("+[>+<]");
        do_reset();
        repeat (20) @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        snap_pc = rom_addr; snap_ptr = mem_addr; snap_r1 = ram[1];
        repeat (6) begin
            @(negedge clk);
            check("freeze_pc", 32'(rom_addr), 32'(snap_pc));
            check("freeze_ptr", 32'(mem_addr), 32'(snap_ptr));
            check("freeze_we", 32'(mem_we), 32'd0);
            check("freeze_ram1", 32'(ram[1]), 32'(snap_r1));
        end
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("freeze_resume", 32'(ram[1] > snap_r1), 32'd1);
        check("freeze_not_halted", 32'({halted, error}), 32'd0);
        $display("freeze: pc=%0d ptr=%0d ram1 %0d -> %0d", snap_pc, snap_ptr, snap_r1, ram[1]);

        // Async reset in the middle of an output handshake
        load("+.");
        do_reset();
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1 seen = out_valid;
        end
        check("async_out_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_drop", 32'(out_valid), 32'd0);
        check("async_out_pc", 32'(rom_addr), 32'd0);
        $display("async reset during out handshake");

        // Async reset in the middle of an input handshake
        load(",");
        do_reset();
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1 seen = in_ready;
        end
        check("async_in_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_in_drop", 32'(in_ready), 32'd0);
        $display("async reset during in handshake");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
